ps2_keyboard: RTL and testbench
===============================

# ps2_keyboard

PS/2 device-to-host receiver. Oversamples the keyboard's `ps2_clk`/`ps2_data` lines with the system clock, deframes 11-bit PS/2 frames, checks them, and queues valid scan-code bytes in a small FIFO. Sits between the PS/2 pins and any consumer, which pops bytes with a ready/next handshake. Scan-code interpretation (make/break, E0 prefixes) is out of scope.

## Interface
- `FIFO_DEPTH`, 8: scan-code FIFO entries; power of two, ≥2.
- `TIMEOUT`, 50000: clk cycles without a `ps2_clk` falling edge before a partial frame is discarded.
- `clk` in 1: system clock, much faster than `ps2_clk` (≥ 1 MHz).
- `clrn` in 1: reset; asynchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock from the device, asynchronous.
- `ps2_data` in 1: raw PS/2 data from the device.
- `nextdata_n` in 1: active-low pop request.
- `data` out 8: byte at the FIFO head; valid while `ready`=1.
- `ready` out 1: FIFO non-empty.
- `overflow` out 1: a valid frame was dropped because the FIFO was full; sticky.

## Operation
- `ps2_clk` passes through a 3-flop synchronizer `s[0]→s[1]→s[2]`. A falling edge is detected in a cycle when `s[2]`=1 and `s[1]`=0. No other edge detection.
- On each detected falling edge, sample `ps2_data` directly; it is stable mid-low-phase. Shift it into a 10-bit frame buffer at position `bitcnt`, then increment the 4-bit `bitcnt`.
- Frame bit order: start (0), d0..d7 LSB first, odd parity, stop (1).
- On the 11th edge (`bitcnt`=10), use the incoming bit as the stop bit and reset `bitcnt` to 0. The frame is valid iff start=0, stop=1, and XOR of d0..d7 and parity = 1.
  - Valid frame: push d7..d0 into the FIFO.
  - Invalid frame: discard silently; no flag.
- FIFO:
  - Circular buffer with write and read pointers plus an occupancy count (or one extra pointer bit).
  - `ready` = not empty. `data` = `mem[rptr]`, combinational from storage.
  - Pop occurs on a clk edge when `ready`=1 and `nextdata_n`=0. A pop request while empty is ignored.
  - Push and pop in the same cycle are both performed, including when the FIFO is full; no overflow results in that case.
  - Push when full with no simultaneous pop: the byte is dropped, `overflow` is set, and FIFO contents are unchanged.
  - `overflow` clears on the next successful pop or on reset.
- Watchdog: while `bitcnt`≠0, count clk cycles since the last detected falling edge. On reaching `TIMEOUT`, set `bitcnt` to 0 and discard the partial frame. The counter reloads on each edge and holds 0 while idle.
- Reset (`clrn`=0, asynchronous):
  - Synchronizer flops go to 1 (idle line).
  - `bitcnt`, pointers, count and watchdog go to 0; `overflow`=0.
  - `ready`=0; `data` is don't-care.
  - A frame in progress when reset is applied is lost. After release, reception resumes at the next start bit only if the line was idle at release. Otherwise the watchdog resynchronizes.

## Timing
- Latency: the 11th `ps2_clk` falling edge at the pin is captured by `s[0]` at clk edge 1 and reaches `s[1]` at edge 2, where it is detected. The push occurs at edge 3, so `ready` and `data` are valid after edge 3.
- A pop at edge k makes the next entry, or `ready`=0, visible after edge k.
- A consumer tying `nextdata_n`=~`ready` sees each byte for exactly one cycle.
- `ps2_data` needs no synchronizer. It must be stable for ≥2 clk cycles around the detected edge, which is always true at PS/2 rates.
- Glitches on `ps2_clk` shorter than one clk period may be filtered or counted; the device clock is assumed clean.

## Test plan
- Reset, then one frame for 0x1C (bits 0,0,0,1,1,1,0,0,0 parity 0, stop 1) with `nextdata_n`=1 → `ready` rises 3 clk after the last fall; `data`=0x1C; `overflow`=0. Pull `nextdata_n` low for one cycle → `ready`=0.
- Frames 0xF0 then 0x1C with no pops → two entries. Pops return 0xF0 then 0x1C in order; `ready` drops after the second pop.
- Frame with bad parity (0x1C, parity 1), bad start (1), or bad stop (0) → nothing queued and `ready` stays 0. A following good frame 0x32 is received correctly.
- 9 valid frames, no pops, `FIFO_DEPTH`=8 → after the 9th, `overflow`=1, `ready`=1, and the 8 pops return the first 8 bytes. `overflow` clears on the first pop.
- 5 bits of a frame, then idle for `TIMEOUT`+10 cycles, then a full 0x45 frame → only 0x45 received.
- Push arriving while full in the same cycle as a pop → byte accepted, `overflow` stays 0. Assert `clrn` mid-frame → all outputs at reset values immediately.

Source files
------------

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver.
// Samples ps2_clk/ps2_data with the system clock, checks each 11-bit
// frame, and queues good scan-code bytes in a small FIFO that the
// consumer pops with a ready/next handshake.
module ps2_keyboard #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

    // ps2_clk synchronizer: sync_q[0] -> sync_q[1] -> sync_q[2]
    logic [2:0]    sync_q;

    // Frame receiver state
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    frame_q,  frame_d;
    logic [WW-1:0] wdog_q,   wdog_d;
    logic          fall;
    logic          push_req;

    // FIFO state
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full;
    logic          push;
    logic          pop;

    // Falling edge of the synchronized PS/2 clock.
    assign fall = sync_q[2] & ~sync_q[1];

    // Shift raw ps2_clk into the synchronizer; resets to the idle (high) line.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync_q <= 3'b111;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop in the
            // chain samples its predecessor's old value in the same edge.
            sync_q <= {sync_q[1:0], ps2_clk};
        end
    end

    // Receiver next state: collect bits on each fall, judge the frame on the
    // 11th, and abandon a partial frame after TIMEOUT idle cycles.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned and infers a latch.
        bitcnt_d = bitcnt_q;
        frame_d  = frame_q;
        wdog_d   = wdog_q;
        push_req = 1'b0;
        if (fall) begin
            wdog_d = '0;
            if (bitcnt_q == 4'd10) begin
                // Incoming bit is the stop bit; frame_q[0] start, [8:1] data,
                // [9] odd parity.
                bitcnt_d = '0;
                push_req = ~frame_q[0] & ps2_data & (^frame_q[9:1]);
            end else begin
                frame_d[bitcnt_q] = ps2_data;
                bitcnt_d          = bitcnt_q + 4'd1;
            end
        end else if (bitcnt_q != 4'd0) begin
            if (wdog_q == WDOG_LAST) begin
                bitcnt_d = '0;
                wdog_d   = '0;
            end else begin
                wdog_d = wdog_q + WW'(1);
            end
        end else begin
            wdog_d = '0;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bitcnt_q <= '0;
            frame_q  <= '0;
            wdog_q   <= '0;
        end else begin
            bitcnt_q <= bitcnt_d;
            frame_q  <= frame_d;
            wdog_q   <= wdog_d;
        end
    end

    // FIFO handshake: a pop always frees a slot for a same-cycle push.
    assign full     = (count_q == COUNT_FULL);
    assign ready    = (count_q != '0);
    assign data     = mem_q[rptr_q];
    assign overflow = overflow_q;
    assign pop      = ready & ~nextdata_n;
    assign push     = push_req & (~full | pop);

    // FIFO pointer, occupancy and sticky overflow next state.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (pop) begin
            overflow_d = 1'b0;
        end else if (push_req && full) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write port.
    // NOTE: storage has no reset; the count gates every read, so stale
    // contents are never observed and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= frame_q[8:1];
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: table of single frames plus
// sequences for latency, ordering, overflow, watchdog and reset.
module tb_ps2_keyboard;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    ps2_keyboard #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] code;
        logic       start;
        logic       pflip;
        logic       stop;
        logic       queued;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame bits in send order: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] mk(input logic [7:0] d, input logic start,
                                       input logic pflip, input logic stop);
        return {stop, (~^d) ^ pflip, d, start};
    endfunction

    // mode 0: plain; 1: check push latency on the last fall;
    // 2: request a pop that lands on the same clk edge as the push.
    task automatic send_bits(input logic [10:0] f, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                repeat (2) @(negedge clk);
                check("latency_not_before_edge3", ready, 1'b0);
                @(negedge clk);
                check("latency_ready_after_edge3", ready, 1'b1);
                repeat (7) @(negedge clk);
            end else if (i == 10 && mode == 2) begin
                repeat (2) @(negedge clk);
                nextdata_n = 1'b0;
                @(negedge clk);
                nextdata_n = 1'b1;
                repeat (7) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(mk(d, 1'b0, 1'b0, 1'b1), 11, 0);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        check({name, "_ready"}, ready, 1'b1);
        check({name, "_data"}, data, exp);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"good_1C",    8'h1C, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{"good_F0",    8'hF0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{"bad_parity", 8'h1C, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{"bad_start",  8'h1C, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{"bad_stop",   8'h1C, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"good_32",    8'h32, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{"good_00",    8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{"good_FF",    8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};

        clrn       = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_ready", ready, 1'b0);

        // First frame with latency check, then a single pop.
        send_bits(mk(8'h1C, 1'b0, 1'b0, 1'b1), 11, 1);
        check("first_data", data, 8'h1C);
        check("first_overflow", overflow, 1'b0);
        pop_expect("first_pop", 8'h1C);
        check("first_empty", ready, 1'b0);

        // Table of single frames.
        for (int i = 0; i < 8; i++) begin
            send_bits(mk(vecs[i].code, vecs[i].start, vecs[i].pflip, vecs[i].stop), 11, 0);
            repeat (3) @(negedge clk);
            check({vecs[i].name, "_queued"}, ready, vecs[i].queued);
            if (vecs[i].queued) pop_expect(vecs[i].name, vecs[i].code);
            check({vecs[i].name, "_empty"}, ready, 1'b0);
        end

        // Two frames, pops in order.
        send_byte(8'hF0);
        send_byte(8'h1C);
        pop_expect("order_0", 8'hF0);
        pop_expect("order_1", 8'h1C);
        check("order_empty", ready, 1'b0);

        // Nine frames into an eight-deep FIFO.
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
        check("ovf_set", overflow, 1'b1);
        check("ovf_ready", ready, 1'b1);
        pop_expect("ovf_pop0", 8'h10);
        check("ovf_cleared", overflow, 1'b0);
        for (int i = 1; i < 8; i++) pop_expect("ovf_pop", 8'h10 + 8'(i));
        check("ovf_empty", ready, 1'b0);

        // Partial frame abandoned by the watchdog.
        send_bits(mk(8'hAA, 1'b0, 1'b0, 1'b1), 5, 0);
        repeat (TMO + 10) @(negedge clk);
        send_byte(8'h45);
        pop_expect("timeout", 8'h45);
        check("timeout_empty", ready, 1'b0);

        // Push landing on a pop while full.
        for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i));
        check("full_no_ovf", overflow, 1'b0);
        send_bits(mk(8'h99, 1'b0, 1'b0, 1'b1), 11, 2);
        check("pushpop_ovf", overflow, 1'b0);
        for (int i = 1; i < 8; i++) pop_expect("pushpop", 8'h20 + 8'(i));
        pop_expect("pushpop_new", 8'h99);
        check("pushpop_empty", ready, 1'b0);

        // Reset in the middle of a frame with a full, overflowed FIFO.
        for (int i = 0; i < 9; i++) send_byte(8'h40 + 8'(i));
        send_bits(mk(8'h77, 1'b0, 1'b0, 1'b1), 4, 0);
        check("pre_rst_ovf", overflow, 1'b1);
        clrn = 1'b0;
        #1;
        check("midrst_ready", ready, 1'b0);
        check("midrst_overflow", overflow, 1'b0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'h5A);
        pop_expect("after_rst", 8'h5A);
        check("after_rst_empty", ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
